// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer: drives PC and memory-address selects, IR/RF write
// enables, wait-state timeout, halt handling and the retired-instruction counter.
module fetch_seq_ctrl #(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_ready_i,
    input  logic             is_load_i,
    input  logic             is_store_i,
    input  logic             is_jump_i,
    input  logic             branch_taken_i,
    input  logic             replay_req_i,
    input  logic             halt_req_i,
    output logic [1:0]       pc_sel_o,
    output logic             mem_sel_o,
    output logic             ir_we_o,
    output logic             rf_we_o,
    output logic             busy_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam int unsigned WaitW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);

    localparam logic [1:0] PcAlu  = 2'b00;
    localparam logic [1:0] PcInc  = 2'b01;
    localparam logic [1:0] PcDec  = 2'b10;
    localparam logic [1:0] PcHold = 2'b11;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StExec,
        StMem,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             ld_pend_q, ld_pend_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            wait_cnt_q <= '0;
            ld_pend_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ld_pend_q  <= ld_pend_d;
            bus_err_q  <= bus_err_d;
            instret_q  <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ld_pend_d  = ld_pend_q;
        bus_err_d  = bus_err_q;
        instret_d  = instret_q;
        pc_sel_o   = PcHold;
        mem_sel_o  = 1'b0;
        ir_we_o    = 1'b0;
        rf_we_o    = 1'b0;
        busy_o     = 1'b1;

        unique case (state_q)
            StBoot: state_d = StFetch;

            StFetch: begin
                if (halt_req_i) begin
                    state_d = StHalt;
                end else if (mem_ready_i) begin
                    pc_sel_o   = PcInc;
                    ir_we_o    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StExec;
                end else if (wait_cnt_q == WaitLast) begin
                    // Counter stays at its last value once the timeout fires.
                    bus_err_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            StExec: begin
                if (replay_req_i) begin
                    pc_sel_o = PcDec;
                    state_d  = StFetch;
                end else if (is_jump_i || branch_taken_i) begin
                    pc_sel_o  = PcAlu;
                    rf_we_o   = is_jump_i;
                    instret_d = instret_q + 1'b1;
                    state_d   = StFetch;
                end else if (is_load_i || is_store_i) begin
                    mem_sel_o  = 1'b1;
                    ld_pend_d  = is_load_i;
                    wait_cnt_d = '0;
                    state_d    = StMem;
                end else begin
                    rf_we_o   = 1'b1;
                    instret_d = instret_q + 1'b1;
                    state_d   = StFetch;
                end
            end

            StMem: begin
                mem_sel_o = 1'b1;
                if (mem_ready_i) begin
                    rf_we_o    = ld_pend_q;
                    instret_d  = instret_q + 1'b1;
                    ld_pend_d  = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = StFetch;
                end else if (wait_cnt_q == WaitLast) begin
                    bus_err_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            StHalt: begin
                busy_o = 1'b0;
                if (!bus_err_q && !halt_req_i) begin
                    state_d = StFetch;
                end
            end

            default: state_d = StBoot;
        endcase

        // Reset cycle: no writes, no PC movement, regardless of the current state.
        if (rst) begin
            pc_sel_o  = PcHold;
            mem_sel_o = 1'b0;
            ir_we_o   = 1'b0;
            rf_we_o   = 1'b0;
            busy_o    = 1'b1;
        end
    end

    assign bus_err_o = bus_err_q;
    assign instret_o = instret_q;

endmodule
